rr_hold_arbiter: RTL and testbench
==================================

Name: rr_hold_arbiter

Overview:
- Round-robin arbiter with grant hold and quantum-based preemption.
- Shares one resource among N requesters. Typical use: a shared UART TX channel or a register bus.
- Successor to the fixed-priority arbiter. Removes starvation and keeps a granted requester stable across multi-cycle transfers.
- Grant outputs are registered. The block sits between requester front-ends and the shared resource mux.

Parameters:
- N, 4, number of requesters (legal range 2..16).
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others are waiting (legal range 1..255).
- ID_W, $clog2(N), width of grant_id.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i high while requester i wants or keeps the resource.
- grant  output  N  registered grant, one-hot or all-zero.
- grant_id  output  ID_W  binary index of the current owner; 0 when grant==0.
- busy  output  1  high iff grant!=0.
- hold_cnt  output  8  cycles the current owner has held the grant, 0-based; debug/visibility only.

Behaviour:
- Reset, asynchronous on rst_n low:
  - grant=0, grant_id=0, busy=0, hold_cnt=0.
  - state=IDLE.
  - last_ptr=N-1, so requester 0 wins the first arbitration.
- Two states: IDLE and OWNED. All decisions use req sampled at the rising edge; the outputs change at that same edge.
- IDLE:
  - req==0: stay in IDLE.
  - req!=0: grant the first set bit searching from last_ptr+1 upward with wrap.
  - Go to OWNED, hold_cnt=0, last_ptr=winner.
  - Latency from first request to grant is 1 edge.
- OWNED with owner k:
  - (a) req[k]==0 (release): re-arbitrate in the same edge over req, search from k+1. Winner exists: grant it, hold_cnt=0, no bubble cycle. None: grant=0, go to IDLE.
  - (b) req[k]==1, hold_cnt==MAX_HOLD-1, and (req & ~(1<<k))!=0 (quantum expiry): grant the next requester searching from k+1, skipping k. hold_cnt=0.
  - (c) req[k]==1, hold_cnt==MAX_HOLD-1, no other requester: keep k, hold_cnt=0. The new quantum starts with no grant gap.
  - (d) otherwise: keep k, hold_cnt+1.
- last_ptr updates on every new grant.
- Invariants:
  - grant is always one-hot or zero.
  - grant_id and busy are always consistent with grant.
  - grant never changes while the owner's req is high and hold_cnt<MAX_HOLD-1.
- Starvation bound: a requester asserted continuously is granted within (N-1)*MAX_HOLD+1 edges.
- Requests for non-owners that rise and fall between edges are ignored; there is no latching.
- MAX_HOLD==1: the grant rotates every cycle among the active requesters.
- Reset asserted mid-operation clears the grant immediately, without waiting for a clock edge. Arbitration after release restarts from requester 0.
- Width rules:
  - hold_cnt is 8 bits and never exceeds MAX_HOLD-1.
  - Pointer increment wraps modulo N; non-power-of-2 N must wrap correctly. For example, with N=3, index 2+1 wraps to 0.

Decomposition:
- Package arb_pkg holds:
  - state encoding (ARB_IDLE, ARB_OWNED);
  - function onehot_to_idx;
  - localparam HOLD_W=8.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req[N-1:0], start_idx, exclude mask.
  - Outputs: found, idx, onehot.
  - Implemented as a double-width mask/priority search.
- rr_hold_arbiter holds only the state, pointer, counter and output registers. rr_pick is unit-testable on its own.

Test Plan (N=4, MAX_HOLD=4 unless stated):
1. Reset and first grant: rst_n=0 with req=4'b1111 -> grant=0000, busy=0, grant_id=0. Release reset -> the first edge gives grant=0001, grant_id=0.
2. Quantum rotation: req=1111 held for 20 cycles -> grant goes 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001. hold_cnt cycles 0,1,2,3.
3. Release without bubble: owner 0 with req=0101, then req->0100 -> the next edge gives grant=0100, hold_cnt=0. Then req->0000 -> grant=0000, busy=0 on the next edge.
4. Sole requester: req=1000 for 12 cycles -> grant=1000 every cycle, no gap. hold_cnt wraps 3->0.
5. Async reset mid-hold: grant=0100, hold_cnt=2, rst_n pulsed low between edges -> grant=0000 immediately. After release with req=1111 -> grant=0001.
6. Random stress, 2000 cycles, N=3, MAX_HOLD=2, random req:
   - every cycle grant is onehot0 and grant_id matches grant;
   - the owner never changes while its req is high and hold_cnt<1;
   - a continuously asserted requester is granted within 5 edges.

Source files
------------

// File: rtl/rr_hold_arbiter_pkg.sv
// Shared definitions for the round-robin hold arbiter: FSM encoding,
// counter width and a one-hot to index helper.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    localparam int HOLD_W = 8;

    // Sized for the largest legal requester count (16).
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// Combinational round-robin picker: first set bit of (req & ~exclude)
// at or above start_idx, wrapping, found via a double-width priority search.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start_idx,
    input  logic [N-1:0]    exclude,
    output logic            found,
    output logic [ID_W-1:0] idx,
    output logic [N-1:0]    onehot
);

    localparam int W2 = 2 * N;

    logic [N-1:0]  w_masked;
    logic [W2-1:0] w_dbl;
    logic [W2-1:0] w_mask;
    logic [W2-1:0] w_cand;
    logic [W2-1:0] w_hit;

    assign w_masked = req & ~exclude;
    assign w_dbl    = {w_masked, w_masked};
    // Drop bits below start_idx; the upper copy supplies the wrapped candidates.
    assign w_mask   = ~((W2'(1) << start_idx) - W2'(1));
    assign w_cand   = w_dbl & w_mask;
    assign w_hit    = w_cand & (~w_cand + W2'(1));

    assign found  = |w_masked;
    assign onehot = w_hit[N-1:0] | w_hit[W2-1:N];
    assign idx    = ID_W'(onehot_to_idx(16'(onehot)));

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with registered grant, grant hold while the owner
// keeps requesting, and preemption once a MAX_HOLD-cycle quantum expires.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    output logic [N-1:0]      grant,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy,
    output logic [HOLD_W-1:0] hold_cnt
);

    arb_state_t        r_state,    w_state_nxt;
    logic [N-1:0]      r_grant,    w_grant_nxt;
    logic [ID_W-1:0]   r_grant_id, w_id_nxt;
    logic [ID_W-1:0]   r_last_ptr, w_last_nxt;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;

    logic [ID_W-1:0]   w_start;
    logic [N-1:0]      w_excl;
    logic              w_found;
    logic [ID_W-1:0]   w_idx;
    logic [N-1:0]      w_oh;
    logic              w_owner_req;
    logic              w_quantum_end;

    // While owned, last_ptr equals the owner, so one picker serves every case.
    assign w_start       = (r_last_ptr == ID_W'(N - 1)) ? '0 : r_last_ptr + ID_W'(1);
    assign w_excl        = (r_state == ARB_OWNED) ? r_grant : '0;
    assign w_owner_req   = req[r_grant_id];
    assign w_quantum_end = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req       (req),
        .start_idx (w_start),
        .exclude   (w_excl),
        .found     (w_found),
        .idx       (w_idx),
        .onehot    (w_oh)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_id_nxt    = r_grant_id;
        w_last_nxt  = r_last_ptr;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ARB_OWNED;
                    w_grant_nxt = w_oh;
                    w_id_nxt    = w_idx;
                    w_last_nxt  = w_idx;
                    w_hold_nxt  = '0;
                end
            end
            ARB_OWNED: begin
                if (!w_owner_req || w_quantum_end) begin
                    w_hold_nxt = '0;
                    if (w_found) begin
                        w_grant_nxt = w_oh;
                        w_id_nxt    = w_idx;
                        w_last_nxt  = w_idx;
                    end else if (!w_owner_req) begin
                        w_state_nxt = ARB_IDLE;
                        w_grant_nxt = '0;
                        w_id_nxt    = '0;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
                w_id_nxt    = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_last_ptr <= ID_W'(N - 1);
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_id_nxt;
            r_last_ptr <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == ARB_OWNED);
    assign hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: directed checks on an N=4/MAX_HOLD=4 instance and
// random stress on an N=3/MAX_HOLD=2 instance, both against a rule-level model.
module tb_rr_hold_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] req_a = '0;
    logic [3:0] grant_a;
    logic [1:0] id_a;
    logic       busy_a;
    logic [7:0] hold_a;

    logic [2:0] req_b = '0;
    logic [2:0] grant_b;
    logic [1:0] id_b;
    logic       busy_b;
    logic [7:0] hold_b;

    int n_pass  = 0;
    int n_total = 0;

    // Model state per instance (0: N=4/MH=4, 1: N=3/MH=2); owner -1 means none.
    int m_owner[2];
    int m_cnt[2];
    int m_last[2];

    always #5 clk = ~clk;

    rr_hold_arbiter #(.N(4), .MAX_HOLD(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .grant(grant_a), .grant_id(id_a), .busy(busy_a), .hold_cnt(hold_a)
    );

    rr_hold_arbiter #(.N(3), .MAX_HOLD(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .grant(grant_b), .grant_id(id_b), .busy(busy_b), .hold_cnt(hold_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int search(input int n, input int from, input logic [15:0] rq, input int skip);
        for (int j = 1; j <= n; j++) begin
            int c;
            c = (from + j) % n;
            if (c != skip && rq[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner[0] = -1; m_cnt[0] = 0; m_last[0] = 3;
        m_owner[1] = -1; m_cnt[1] = 0; m_last[1] = 2;
    endtask

    task automatic model_step(input int u, input int n, input int mh, input logic [15:0] rq);
        int w;
        if (m_owner[u] < 0) begin
            if (rq != 0) begin
                w = search(n, m_last[u], rq, -1);
                m_owner[u] = w; m_last[u] = w; m_cnt[u] = 0;
            end
        end else if (!rq[m_owner[u]]) begin
            w = search(n, m_owner[u], rq, -1);
            if (w >= 0) m_last[u] = w;
            m_owner[u] = w;
            m_cnt[u] = 0;
        end else if (m_cnt[u] == mh - 1) begin
            w = search(n, m_owner[u], rq, m_owner[u]);
            if (w >= 0) begin
                m_owner[u] = w; m_last[u] = w;
            end
            m_cnt[u] = 0;
        end else begin
            m_cnt[u]++;
        end
    endtask

    task automatic compare_all();
        int oa, ob;
        oa = m_owner[0];
        ob = m_owner[1];
        chk("a_grant", 32'(grant_a), (oa < 0) ? 0 : (1 << oa));
        chk("a_id",    32'(id_a),    (oa < 0) ? 0 : oa);
        chk("a_busy",  32'(busy_a),  (oa < 0) ? 0 : 1);
        chk("a_hold",  32'(hold_a),  (oa < 0) ? 0 : m_cnt[0]);
        chk("b_grant", 32'(grant_b), (ob < 0) ? 0 : (1 << ob));
        chk("b_id",    32'(id_b),    (ob < 0) ? 0 : ob);
        chk("b_busy",  32'(busy_b),  (ob < 0) ? 0 : 1);
        chk("b_hold",  32'(hold_b),  (ob < 0) ? 0 : m_cnt[1]);
    endtask

    // Called just after a negedge: drive, clock, advance model, sample at negedge.
    task automatic step(input logic [3:0] ra, input logic [2:0] rb);
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        model_step(0, 4, 4, 16'(ra));
        model_step(1, 3, 2, 16'(rb));
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input logic [3:0] ra);
        req_a = ra;
        req_b = '0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] rb;
        logic [2:0] prev_grant_b;
        logic [7:0] prev_hold_b;
        int         wait_b[3];

        model_reset();
        @(negedge clk);

        // Reset held with all requesting, then first grant one edge after release
        do_reset(4'b1111);
        chk("t1_rst_grant", 32'(grant_a), 0);
        chk("t1_rst_busy",  32'(busy_a),  0);
        step(4'b1111, 3'b000);
        chk("t1_first_grant", 32'(grant_a), 1);

        // Quantum rotation: edge i (1-based) owner ((i-1)/4)%4, hold (i-1)%4
        for (int i = 2; i <= 21; i++) begin
            step(4'b1111, 3'b000);
            chk("t2_rot_grant", 32'(grant_a), 1 << (((i - 1) / 4) % 4));
            chk("t2_rot_hold",  32'(hold_a),  (i - 1) % 4);
        end

        // Release hands over with no bubble, then full release idles
        do_reset(4'b0000);
        step(4'b0101, 3'b000);
        chk("t3_owner0", 32'(grant_a), 1);
        step(4'b0100, 3'b000);
        chk("t3_handover_grant", 32'(grant_a), 4);
        chk("t3_handover_hold",  32'(hold_a),  0);
        step(4'b0000, 3'b000);
        chk("t3_idle_grant", 32'(grant_a), 0);
        chk("t3_idle_busy",  32'(busy_a),  0);

        // Sole requester keeps the grant across quantum boundaries
        for (int i = 0; i < 12; i++) begin
            step(4'b1000, 3'b000);
            chk("t4_sole_grant", 32'(grant_a), 8);
        end

        // Asynchronous reset in the middle of a hold
        do_reset(4'b0000);
        for (int i = 0; i < 3; i++) step(4'b0100, 3'b000);
        chk("t5_pre_grant", 32'(grant_a), 4);
        chk("t5_pre_hold",  32'(hold_a),  2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_grant", 32'(grant_a), 0);
        chk("t5_async_busy",  32'(busy_a),  0);
        chk("t5_async_hold",  32'(hold_a),  0);
        model_reset();
        #1 rst_n = 1'b1;
        step(4'b1111, 3'b000);
        chk("t5_after_grant", 32'(grant_a), 1);

        // Random stress on the N=3 / MAX_HOLD=2 instance
        do_reset(4'b0000);
        rb = '0;
        prev_grant_b = '0;
        prev_hold_b = '0;
        for (int i = 0; i < 3; i++) wait_b[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            bit stable_expected;
            int k;
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) rb[i] = ~rb[i];
            end
            k = -1;
            for (int i = 0; i < 3; i++) if (prev_grant_b[i]) k = i;
            stable_expected = (k >= 0) && rb[k] && (prev_hold_b < 8'd1);
            step(4'b0000, rb);
            chk("b_onehot0", 32'((grant_b & (grant_b - 3'd1)) == 3'd0), 1);
            begin
                int gid;
                gid = 0;
                for (int i = 0; i < 3; i++) if (grant_b[i]) gid = i;
                chk("b_id_consistent", 32'(id_b), gid);
                chk("b_busy_consistent", 32'(busy_b), 32'(grant_b != 3'd0));
            end
            if (stable_expected) chk("b_hold_stable", 32'(grant_b), 32'(prev_grant_b));
            for (int i = 0; i < 3; i++) begin
                if (rb[i] && !grant_b[i]) wait_b[i]++;
                else wait_b[i] = 0;
                chk("b_starvation", 32'(wait_b[i] < 5), 1);
            end
            prev_grant_b = grant_b;
            prev_hold_b  = hold_b;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
